// File: rtl/axi_addr_router_if.sv
// Requester-side bus for axi_addr_router: independent write and read
// request/response channels between the AXI-lite slave and the router.
interface axi_addr_router_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wdone;
    logic              werr;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic              rdone;
    logic              rerr;
    logic [DATA_W-1:0] rdata;

    modport master (
        output we, waddr, wdata, re, raddr,
        input  wdone, werr, rdone, rerr, rdata
    );

    modport slave (
        input  we, waddr, wdata, re, raddr,
        output wdone, werr, rdone, rerr, rdata
    );
endinterface

// File: rtl/axi_addr_router.sv
// Address router: decodes write/read requests onto N_TGT register targets
// with base/mask matching, per-channel FSMs and an ack timeout.
module axi_addr_router #(
    parameter int                       N_TGT       = 4,
    parameter int                       ADDR_W      = 32,
    parameter int                       DATA_W      = 32,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE    = {32'hA000_0000, 32'h9000_0000,
                                                       32'h8000_0000, 32'h0000_0000},
    parameter logic [N_TGT*ADDR_W-1:0] TGT_MASK    = {32'hF000_0000, 32'hF000_0000,
                                                       32'hF000_0000, 32'h8000_0000},
    parameter int                       TIMEOUT_CYC = 256,
    parameter logic [DATA_W-1:0]        ERR_DATA    = 32'hDEC0_DEAD
) (
    input  logic                    clk,
    input  logic                    rst_n,
    axi_addr_router_if.slave        bus,
    output logic [N_TGT-1:0]        tgt_we,
    output logic [ADDR_W-1:0]       tgt_waddr,
    output logic [DATA_W-1:0]       tgt_wdata,
    input  logic [N_TGT-1:0]        tgt_wdone,
    output logic [N_TGT-1:0]        tgt_re,
    output logic [ADDR_W-1:0]       tgt_raddr,
    input  logic [N_TGT-1:0]        tgt_rdone,
    input  logic [N_TGT*DATA_W-1:0] tgt_rdata
);
    localparam int SEL_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    w_state_t w_state, w_nxt;
    r_state_t r_state, r_nxt;

    logic              w_hit, r_hit;
    logic [SEL_W-1:0]  w_sel_d, r_sel_d, w_sel, r_sel;
    logic [ADDR_W-1:0] w_off_d, r_off_d, w_off, r_off;
    logic [DATA_W-1:0] w_dat, r_data;
    logic              w_err, r_err;
    logic [CNT_W-1:0]  w_cnt, r_cnt;
    logic              w_ack, r_ack, w_tmo, r_tmo;

    // Scan high to low so the lowest matching index wins.
    function automatic void decode(
        input  logic [ADDR_W-1:0] a,
        output logic              hit,
        output logic [SEL_W-1:0]  sel,
        output logic [ADDR_W-1:0] off
    );
        hit = 1'b0;
        sel = '0;
        off = '0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if ((a & TGT_MASK[i*ADDR_W +: ADDR_W]) == TGT_BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                sel = SEL_W'(i);
                off = a & ~TGT_MASK[i*ADDR_W +: ADDR_W];
            end
        end
    endfunction

    always_comb begin
        decode(bus.waddr, w_hit, w_sel_d, w_off_d);
    end

    always_comb begin
        decode(bus.raddr, r_hit, r_sel_d, r_off_d);
    end

    assign w_ack = tgt_wdone[w_sel];
    assign r_ack = tgt_rdone[r_sel];
    assign w_tmo = (TIMEOUT_CYC != 0) && (w_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign r_tmo = (TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        w_nxt = w_state;
        unique case (w_state)
            W_IDLE:  if (bus.we) w_nxt = w_hit ? W_WAIT : W_RESP;
            W_WAIT:  if (w_ack || w_tmo) w_nxt = W_RESP;
            W_RESP:  w_nxt = W_IDLE;
            default: w_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_nxt = r_state;
        unique case (r_state)
            R_IDLE:  if (bus.re) r_nxt = r_hit ? R_WAIT : R_RESP;
            R_WAIT:  if (r_ack || r_tmo) r_nxt = R_RESP;
            R_RESP:  r_nxt = R_IDLE;
            default: r_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_sel   <= '0;
            w_off   <= '0;
            w_dat   <= '0;
            w_err   <= 1'b0;
            w_cnt   <= '0;
        end else begin
            w_state <= w_nxt;
            if (w_state == W_IDLE && bus.we) begin
                w_sel <= w_sel_d;
                w_off <= w_off_d;
                w_dat <= bus.wdata;
                w_err <= !w_hit;
                w_cnt <= '0;
            end else if (w_state == W_WAIT) begin
                if (w_ack) w_err <= 1'b0;
                else if (w_tmo) w_err <= 1'b1;
                else if (w_cnt != '1) w_cnt <= w_cnt + 1'b1;
            end
        end
    end

    // rdata is only rewritten when a read finishes, so it holds between rdones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_sel   <= '0;
            r_off   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= r_nxt;
            if (r_state == R_IDLE && bus.re) begin
                r_sel <= r_sel_d;
                r_off <= r_off_d;
                r_err <= !r_hit;
                r_cnt <= '0;
                if (!r_hit) r_data <= ERR_DATA;
            end else if (r_state == R_WAIT) begin
                if (r_ack) begin
                    r_data <= tgt_rdata[r_sel*DATA_W +: DATA_W];
                    r_err  <= 1'b0;
                end else if (r_tmo) begin
                    r_data <= ERR_DATA;
                    r_err  <= 1'b1;
                end else if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign tgt_we    = (w_state == W_WAIT) ? (N_TGT'(1) << w_sel) : '0;
    assign tgt_waddr = (w_state == W_WAIT) ? w_off : '0;
    assign tgt_wdata = (w_state == W_WAIT) ? w_dat : '0;
    assign tgt_re    = (r_state == R_WAIT) ? (N_TGT'(1) << r_sel) : '0;
    assign tgt_raddr = (r_state == R_WAIT) ? r_off : '0;

    assign bus.wdone = (w_state == W_RESP);
    assign bus.werr  = (w_state == W_RESP) && w_err;
    assign bus.rdone = (r_state == R_RESP);
    assign bus.rerr  = (r_state == R_RESP) && r_err;
    assign bus.rdata = r_data;
endmodule

// File: tb/tb_axi_addr_router.sv
// Scenario bench for axi_addr_router: expected responses are queued at
// request time and compared when wdone/rdone appear.
module tb_axi_addr_router;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   tgt_we, tgt_re, tgt_wdone, tgt_rdone;
    logic [31:0]  tgt_waddr, tgt_wdata, tgt_raddr;
    logic [127:0] tgt_rdata;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    axi_addr_router_if bus ();

    axi_addr_router dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .tgt_we    (tgt_we),
        .tgt_waddr (tgt_waddr),
        .tgt_wdata (tgt_wdata),
        .tgt_wdone (tgt_wdone),
        .tgt_re    (tgt_re),
        .tgt_raddr (tgt_raddr),
        .tgt_rdone (tgt_rdone),
        .tgt_rdata (tgt_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.we    = 1'b0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.re    = 1'b0;
        bus.raddr = '0;
        tgt_wdone = '0;
        tgt_rdone = '0;
        tgt_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (tgt_we !== 4'b0 || tgt_re !== 4'b0) begin
            n_err++;
            $display("FAIL reset_strobes we=%b re=%b want 0", tgt_we, tgt_re);
        end
        n_vec++;
        if (bus.wdone !== 1'b0 || bus.rdone !== 1'b0 || bus.rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_resp wdone=%b rdone=%b rdata=%h want 0",
                     bus.wdone, bus.rdone, bus.rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_fast();
        bus.we = 1'b1;
        bus.waddr = 32'h0000_0010;
        bus.wdata = 32'h0000_1234;
        wq.push_back('{1'b0, 32'h0});
        @(negedge clk);
        bus.we = 1'b0;
        n_vec++;
        if (tgt_we !== 4'b0001 || tgt_waddr !== 32'h10 || tgt_wdata !== 32'h1234) begin
            n_err++;
            $display("FAIL wfast_strobe we=%b addr=%h data=%h want 0001/10/1234",
                     tgt_we, tgt_waddr, tgt_wdata);
        end
        tgt_wdone = 4'b0001;
        @(negedge clk);
        tgt_wdone = 4'b0;
        n_vec++;
        if (bus.wdone !== 1'b1 || wq.size() == 0) begin
            n_err++;
            $display("FAIL wfast_latency wdone=%b want 1 at cycle 2", bus.wdone);
        end else begin
            e = wq.pop_front();
            n_vec++;
            if (bus.werr !== e.err || tgt_we !== 4'b0) begin
                n_err++;
                $display("FAIL wfast_resp werr=%b tgt_we=%b want %b/0000",
                         bus.werr, tgt_we, e.err);
            end
        end
        @(negedge clk);
        n_vec++;
        if (bus.wdone !== 1'b0) begin
            n_err++;
            $display("FAIL wfast_pulse wdone=%b want 0", bus.wdone);
        end
    endtask

    task automatic test_write_slow();
        int held = 0;
        bus.we = 1'b1;
        bus.waddr = 32'h9000_0044;
        bus.wdata = 32'hABCD_0001;
        wq.push_back('{1'b0, 32'h0});
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.we = 1'b0;
            if (tgt_we === 4'b0100 && tgt_waddr === 32'h44 && tgt_wdata === 32'hABCD_0001)
                held++;
            if (bus.wdone === 1'b1) held = -100;
            // target 0 acks early and must be ignored
            tgt_wdone = (c == 2) ? 4'b0001 : (c == 6) ? 4'b0100 : 4'b0;
        end
        @(negedge clk);
        tgt_wdone = 4'b0;
        n_vec++;
        if (held !== 6) begin
            n_err++;
            $display("FAIL wslow_hold stable_cycles=%0d want 6", held);
        end
        n_vec++;
        if (bus.wdone !== 1'b1 || wq.size() == 0) begin
            n_err++;
            $display("FAIL wslow_done wdone=%b want 1", bus.wdone);
        end else begin
            e = wq.pop_front();
            n_vec++;
            if (bus.werr !== e.err) begin
                n_err++;
                $display("FAIL wslow_werr werr=%b want %b", bus.werr, e.err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_read_unmapped();
        bus.re = 1'b1;
        bus.raddr = 32'hF000_0000;
        rq.push_back('{1'b1, 32'hDEC0_DEAD});
        @(negedge clk);
        bus.re = 1'b0;
        n_vec++;
        if (bus.rdone !== 1'b1 || rq.size() == 0) begin
            n_err++;
            $display("FAIL rmiss_latency rdone=%b want 1 at cycle 1", bus.rdone);
        end else begin
            e = rq.pop_front();
            n_vec++;
            if (bus.rerr !== e.err || bus.rdata !== e.data || tgt_re !== 4'b0) begin
                n_err++;
                $display("FAIL rmiss_resp rerr=%b rdata=%h tgt_re=%b want %b/%h/0000",
                         bus.rerr, bus.rdata, tgt_re, e.err, e.data);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_read_timeout();
        int held = 0;
        bit done = 1'b0;
        bus.re = 1'b1;
        bus.raddr = 32'h8000_0008;
        rq.push_back('{1'b1, 32'hDEC0_DEAD});
        @(negedge clk);
        bus.re = 1'b0;
        n_vec++;
        if (tgt_re !== 4'b0010 || tgt_raddr !== 32'h8 || bus.rdata !== 32'hDEC0_DEAD) begin
            n_err++;
            $display("FAIL rtmo_start re=%b raddr=%h rdata=%h want 0010/8/dec0dead",
                     tgt_re, tgt_raddr, bus.rdata);
        end
        for (int c = 0; c < 400 && !done; c++) begin
            if (bus.rdone === 1'b1) done = 1'b1;
            else begin
                if (tgt_re === 4'b0010) held++;
                @(negedge clk);
            end
        end
        n_vec++;
        if (!done || rq.size() == 0) begin
            n_err++;
            $display("FAIL rtmo_done rdone never seen within 400 cycles, want 1");
        end else begin
            e = rq.pop_front();
            n_vec++;
            if (held !== 256 || bus.rerr !== e.err || bus.rdata !== e.data) begin
                n_err++;
                $display("FAIL rtmo_resp held=%0d rerr=%b rdata=%h want 256/%b/%h",
                         held, bus.rerr, bus.rdata, e.err, e.data);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_concurrent();
        int extra = 0;
        bus.we = 1'b1;
        bus.waddr = 32'h8000_0100;
        bus.wdata = 32'h0000_0055;
        bus.re = 1'b1;
        bus.raddr = 32'hA000_0020;
        wq.push_back('{1'b0, 32'h0});
        rq.push_back('{1'b0, 32'h0000_CAFE});
        @(negedge clk);
        bus.re = 1'b0;
        bus.waddr = 32'h0000_0000;
        bus.wdata = 32'h0000_0099;
        n_vec++;
        if (tgt_we !== 4'b0010 || tgt_re !== 4'b1000 ||
            tgt_waddr !== 32'h100 || tgt_raddr !== 32'h20) begin
            n_err++;
            $display("FAIL conc_strobes we=%b re=%b wa=%h ra=%h want 0010/1000/100/20",
                     tgt_we, tgt_re, tgt_waddr, tgt_raddr);
        end
        tgt_rdone = 4'b1000;
        tgt_rdata[3*32 +: 32] = 32'h0000_CAFE;
        tgt_rdata[1*32 +: 32] = 32'h0000_0BAD;
        @(negedge clk);
        bus.we = 1'b0;
        tgt_rdone = 4'b0;
        n_vec++;
        if (bus.rdone !== 1'b1 || rq.size() == 0) begin
            n_err++;
            $display("FAIL conc_rdone rdone=%b want 1", bus.rdone);
        end else begin
            e = rq.pop_front();
            n_vec++;
            if (bus.rdata !== e.data || bus.rerr !== e.err) begin
                n_err++;
                $display("FAIL conc_rdata rdata=%h rerr=%b want %h/%b",
                         bus.rdata, bus.rerr, e.data, e.err);
            end
        end
        n_vec++;
        if (tgt_we !== 4'b0010 || tgt_wdata !== 32'h55 || bus.wdone !== 1'b0) begin
            n_err++;
            $display("FAIL conc_wait we=%b wdata=%h wdone=%b want 0010/55/0",
                     tgt_we, tgt_wdata, bus.wdone);
        end
        tgt_wdone = 4'b0010;
        @(negedge clk);
        tgt_wdone = 4'b0;
        n_vec++;
        if (bus.wdone !== 1'b1 || wq.size() == 0) begin
            n_err++;
            $display("FAIL conc_wdone wdone=%b want 1", bus.wdone);
        end else begin
            e = wq.pop_front();
            n_vec++;
            if (bus.werr !== e.err || bus.rdata !== 32'h0000_CAFE) begin
                n_err++;
                $display("FAIL conc_wresp werr=%b rdata=%h want %b/0000cafe",
                         bus.werr, bus.rdata, e.err);
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (tgt_we !== 4'b0 || bus.wdone !== 1'b0) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL conc_dropped_we activity_cycles=%0d want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        bus.we = 1'b1;
        bus.waddr = 32'h0000_0004;
        bus.wdata = 32'h0000_0777;
        wq.push_back('{1'b0, 32'h0});
        @(negedge clk);
        bus.we = 1'b0;
        n_vec++;
        if (tgt_we !== 4'b0001) begin
            n_err++;
            $display("FAIL rmid_wait tgt_we=%b want 0001", tgt_we);
        end
        #2 rst_n = 1'b0;
        wq.delete();
        #1;
        n_vec++;
        if (tgt_we !== 4'b0 || tgt_waddr !== 32'h0 || tgt_wdata !== 32'h0 ||
            bus.rdata !== 32'h0 || bus.wdone !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_async we=%b wa=%h wd=%h rdata=%h wdone=%b want all 0",
                     tgt_we, tgt_waddr, tgt_wdata, bus.rdata, bus.wdone);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.wdone !== 1'b0 || tgt_we !== 4'b0) spurious++;
        end
        n_vec++;
        if (spurious !== 0) begin
            n_err++;
            $display("FAIL rmid_nodone spurious_cycles=%0d want 0", spurious);
        end
        bus.we = 1'b1;
        bus.waddr = 32'h0000_0020;
        bus.wdata = 32'h0000_0042;
        wq.push_back('{1'b0, 32'h0});
        @(negedge clk);
        bus.we = 1'b0;
        tgt_wdone = tgt_we;
        @(negedge clk);
        tgt_wdone = 4'b0;
        n_vec++;
        if (bus.wdone !== 1'b1 || wq.size() == 0) begin
            n_err++;
            $display("FAIL rmid_after wdone=%b want 1", bus.wdone);
        end else begin
            e = wq.pop_front();
            n_vec++;
            if (bus.werr !== e.err) begin
                n_err++;
                $display("FAIL rmid_after_werr werr=%b want %b", bus.werr, e.err);
            end
        end
        n_vec++;
        if (wq.size() != 0 || rq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover wq=%0d rq=%0d want 0/0", wq.size(), rq.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_fast();
        test_write_slow();
        test_read_unmapped();
        test_read_timeout();
        test_concurrent();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
